// File: rtl/audio_capture.sv
// audio_capture
//   I2S capture path. The bck/lrck/data inputs are asynchronous and oversampled
//   on clk. Each channel's 16-bit word is deserialised and written little-endian
//   into a byte-wide FIFO that the CPU register interface reads. The byte order
//   (L lo, L hi, R lo, R hi) is the same as the playback FIFO, so captured data
//   can be replayed unchanged.
//
//   Ports
//     clk, rst           system clock, synchronous active-high reset
//     i2s_bck/lrck/data  async I2S inputs (lrck 0 = left, data MSB first)
//     capture_enable     1 = deserialise and push frames
//     mode_stereo        1 = push L+R (4 bytes), 0 = push L only (2 bytes)
//     fifo_reset         synchronous flush pulse
//     fifo_read          pop head byte (ignored when empty)
//     fifo_rddata        head byte, first-word fall-through, 8'h00 when empty
//     fifo_empty         fill count == 0
//     fifo_almost_full   fill count >= AFULL_LEVEL
//     fifo_count         fill count in bytes
//     overrun            sticky: a whole frame was dropped for lack of space
module audio_capture #(
  parameter int FIFO_AW     = 10,
  parameter int AFULL_LEVEL = 768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2s_bck,
  input  logic             i2s_lrck,
  input  logic             i2s_data,
  input  logic             capture_enable,
  input  logic             mode_stereo,
  input  logic             fifo_reset,
  input  logic             fifo_read,
  output logic [7:0]       fifo_rddata,
  output logic             fifo_empty,
  output logic             fifo_almost_full,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW+1:0] DEPTH_W   = {2'b01, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW+1:0] NEED_ST   = {{(FIFO_AW-1){1'b0}}, 3'd4};
  localparam logic [FIFO_AW+1:0] NEED_MO   = {{(FIFO_AW-1){1'b0}}, 3'd2};
  localparam logic [FIFO_AW:0]   AFULL_W   = AFULL_LEVEL[FIFO_AW:0];
  localparam logic [4:0]         BIT_IDLE  = 5'd17;

  // ---------------- input synchroniser: {data, lrck, bck} ----------------
  logic [2:0] meta_reg, sync_reg;
  logic       bck_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg     <= 3'b000;
      sync_reg     <= 3'b000;
      bck_prev_reg <= 1'b0;
    end else begin
      meta_reg     <= {i2s_data, i2s_lrck, i2s_bck};
      sync_reg     <= meta_reg;
      bck_prev_reg <= sync_reg[0];
    end
  end

  logic bck_rise, lrck_s, data_s;
  assign bck_rise = sync_reg[0] & ~bck_prev_reg;
  assign lrck_s   = sync_reg[1];
  assign data_s   = sync_reg[2];

  // ---------------- deserialiser ----------------
  // bit_cnt counts data bits since the lrck edge; 17 is the parked value that
  // ignores everything until the next lrck edge.
  logic [4:0]  bit_cnt_reg;
  logic [14:0] shreg_reg;
  logic [15:0] left_reg, right_reg;
  logic        lrck_prev_reg, left_valid_reg;
  logic        frame_done_reg, frame_stereo_reg;
  logic [15:0] word_next;

  // The 16th bit completes the word straight from the line.
  assign word_next = {shreg_reg, data_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg      <= BIT_IDLE;
      shreg_reg        <= '0;
      left_reg         <= '0;
      right_reg        <= '0;
      lrck_prev_reg    <= 1'b0;
      left_valid_reg   <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_stereo_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      // lrck is tracked even while parked so a re-enable or flush restarts
      // cleanly at the next genuine lrck edge.
      if (bck_rise) lrck_prev_reg <= lrck_s;
      if (fifo_reset || !capture_enable) begin
        bit_cnt_reg    <= BIT_IDLE;
        left_valid_reg <= 1'b0;
      end else if (bck_rise) begin
        if (lrck_s != lrck_prev_reg) begin
          // One-bit I2S delay slot: this bit belongs to no word.
          bit_cnt_reg <= 5'd0;
          if (!lrck_s) left_valid_reg <= 1'b0;
        end else if (bit_cnt_reg != BIT_IDLE) begin
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg < 5'd15) shreg_reg <= {shreg_reg[13:0], data_s};
          if (bit_cnt_reg == 5'd15) begin
            if (!lrck_s) begin
              left_reg       <= word_next;
              left_valid_reg <= 1'b1;
              if (!mode_stereo) begin
                frame_done_reg   <= 1'b1;
                frame_stereo_reg <= 1'b0;
              end
            end else begin
              right_reg      <= word_next;
              left_valid_reg <= 1'b0;
              if (mode_stereo && left_valid_reg) begin
                frame_done_reg   <= 1'b1;
                frame_stereo_reg <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- push sequencer ----------------
  typedef enum logic [2:0] {S_IDLE, S_PUSH_LL, S_PUSH_LH, S_PUSH_RL, S_PUSH_RH} state_t;
  state_t state_reg, state_next;
  logic   stereo_reg;
  logic   start, drop, push_en;
  logic [7:0] push_byte;
  logic [FIFO_AW:0]   fifo_count_reg;
  logic [FIFO_AW+1:0] space, need;

  assign space = DEPTH_W - {1'b0, fifo_count_reg};
  assign need  = frame_stereo_reg ? NEED_ST : NEED_MO;

  // left_reg/right_reg stay stable for at least 16 bck periods after
  // frame_done, far longer than the 4-cycle sequence, so no extra copy.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    drop       = 1'b0;
    push_en    = 1'b0;
    push_byte  = 8'h00;
    case (state_reg)
      S_IDLE: begin
        if (frame_done_reg) begin
          if (space >= need) begin
            start      = 1'b1;
            state_next = S_PUSH_LL;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_PUSH_LL: begin
        push_en    = 1'b1;
        push_byte  = left_reg[7:0];
        state_next = S_PUSH_LH;
      end
      S_PUSH_LH: begin
        push_en    = 1'b1;
        push_byte  = left_reg[15:8];
        state_next = stereo_reg ? S_PUSH_RL : S_IDLE;
      end
      S_PUSH_RL: begin
        push_en    = 1'b1;
        push_byte  = right_reg[7:0];
        state_next = S_PUSH_RH;
      end
      S_PUSH_RH: begin
        push_en    = 1'b1;
        push_byte  = right_reg[15:8];
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_reset) begin
      state_reg  <= S_IDLE;
      stereo_reg <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) stereo_reg <= frame_stereo_reg;
      if (drop)  overrun    <= 1'b1;
    end
  end

  // ---------------- byte FIFO ----------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr_next;
  logic [7:0]         rd_data_reg;
  logic               pop;

  assign pop          = fifo_read && (fifo_count_reg != '0);
  assign rd_addr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (rst || fifo_reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_en, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_ONE;
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_ONE;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !rst && !fifo_reset) mem[wr_ptr_reg] <= push_byte;
  end

  // Registered read of the next head. A write landing on that very address
  // (FIFO empty or about to be) is forwarded, since the RAM returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= 8'h00;
    end else if (push_en && (wr_ptr_reg == rd_addr_next)) begin
      rd_data_reg <= push_byte;
    end else begin
      rd_data_reg <= mem[rd_addr_next];
    end
  end

  assign fifo_count       = fifo_count_reg;
  assign fifo_empty       = (fifo_count_reg == '0);
  assign fifo_almost_full = (fifo_count_reg >= AFULL_W);
  assign fifo_rddata      = fifo_empty ? 8'h00 : rd_data_reg;

endmodule

// File: tb/tb_audio_capture.sv
// Directed bench for audio_capture: I2S frames are bit-banged, then the FIFO
// is drained and every byte compared with hand-computed values.
module tb_audio_capture;

  logic        clk = 1'b0;
  logic        rst, i2s_bck, i2s_lrck, i2s_data;
  logic        capture_enable, mode_stereo, fifo_reset, fifo_read;
  logic [7:0]  fifo_rddata;
  logic        fifo_empty, fifo_almost_full, overrun;
  logic [10:0] fifo_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  audio_capture dut (
    .clk(clk), .rst(rst), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .capture_enable(capture_enable), .mode_stereo(mode_stereo), .fifo_reset(fifo_reset),
    .fifo_read(fifo_read), .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_count(fifo_count), .overrun(overrun)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bck_bit(input logic lr, input logic d, input int half);
    i2s_bck = 1'b0; i2s_lrck = lr; i2s_data = d;
    repeat (half) @(negedge clk);
    i2s_bck = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Delay-slot bit followed by nbits of w, MSB first.
  task automatic send_half(input logic lr, input logic [23:0] w, input int nbits, input int half);
    bck_bit(lr, 1'b0, half);
    for (int i = nbits - 1; i >= 0; i--) bck_bit(lr, w[i], half);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nbits,
                            input int half, input bit verbose);
    send_half(1'b0, l, nbits, half);
    send_half(1'b1, r, nbits, half);
    idle(8);
    if (verbose) $display("frame L=%06h R=%06h bits=%0d stereo=%0b -> count=%0d",
                          l, r, nbits, mode_stereo, fifo_count);
  endtask

  task automatic pop1;
    fifo_read = 1'b1;
    @(negedge clk);
    fifo_read = 1'b0;
  endtask

  task automatic flush;
    fifo_reset = 1'b1;
    @(negedge clk);
    fifo_reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; i2s_bck = 0; i2s_lrck = 0; i2s_data = 0;
    capture_enable = 1'b1; mode_stereo = 1'b1; fifo_reset = 0; fifo_read = 0;
    idle(4);
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (fifo_count !== 11'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    nvec++; if (fifo_almost_full !== 1'b0) begin nerr++; $display("FAIL reset_afull: got %b want 0", fifo_almost_full); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    nvec++; if (fifo_rddata !== 8'h00) begin nerr++; $display("FAIL reset_rddata: got %02h want 00", fifo_rddata); end
    pop1;
    nvec++; if (fifo_count !== 11'd0) begin nerr++; $display("FAIL pop_empty_count: got %0d want 0", fifo_count); end
    $display("reset checked, pop on empty ignored");
    // Park lrck high so the first left word begins with a real lrck edge.
    bck_bit(1'b1, 1'b0, 8);
  endtask

  task automatic test_stereo;
    logic [7:0] exp [4] = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    mode_stereo = 1'b1;
    send_frame(24'h1234, 24'hABCD, 16, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd4) begin nerr++; $display("FAIL stereo_count: got %0d want 4", fifo_count); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL stereo_overrun: got %b want 0", overrun); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (fifo_rddata !== exp[i]) begin nerr++; $display("FAIL stereo_byte%0d: got %02h want %02h", i, fifo_rddata, exp[i]); end
      pop1;
    end
    nvec++; if (fifo_empty !== 1'b1 || fifo_rddata !== 8'h00) begin
      nerr++; $display("FAIL stereo_drained: empty=%b rddata=%02h want 1/00", fifo_empty, fifo_rddata); end
  endtask

  task automatic test_mono;
    logic [7:0] exp [2] = '{8'h01, 8'h80};
    mode_stereo = 1'b0;
    send_frame(24'h8001, 24'h7FFF, 16, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd2) begin nerr++; $display("FAIL mono_count: got %0d want 2", fifo_count); end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (fifo_rddata !== exp[i]) begin nerr++; $display("FAIL mono_byte%0d: got %02h want %02h", i, fifo_rddata, exp[i]); end
      pop1;
    end
    nvec++; if (fifo_empty !== 1'b1) begin nerr++; $display("FAIL mono_drained: empty=%b want 1", fifo_empty); end
  endtask

  task automatic test_overrun;
    flush;
    mode_stereo = 1'b1;
    for (int f = 0; f < 255; f++) send_frame(24'h2211, 24'h4433, 16, 4, 1'b0);
    mode_stereo = 1'b0;
    send_frame(24'h2211, 24'h0000, 16, 4, 1'b1);
    nvec++; if (fifo_count !== 11'd1022) begin nerr++; $display("FAIL fill_count: got %0d want 1022", fifo_count); end
    nvec++; if (fifo_almost_full !== 1'b1) begin nerr++; $display("FAIL fill_afull: got %b want 1", fifo_almost_full); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL fill_overrun: got %b want 0", overrun); end
    mode_stereo = 1'b1;
    send_frame(24'hDEAD, 24'hBEEF, 16, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd1022) begin nerr++; $display("FAIL drop_count: got %0d want 1022", fifo_count); end
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL drop_overrun: got %b want 1", overrun); end
    nvec++; if (fifo_rddata !== 8'h11) begin nerr++; $display("FAIL drop_head0: got %02h want 11", fifo_rddata); end
    pop1;
    nvec++; if (fifo_rddata !== 8'h22) begin nerr++; $display("FAIL drop_head1: got %02h want 22", fifo_rddata); end
    pop1;
    send_frame(24'h5566, 24'h7788, 16, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd1024) begin nerr++; $display("FAIL refill_count: got %0d want 1024", fifo_count); end
  endtask

  task automatic test_wrap_flush;
    logic [7:0] exp [8] = '{8'h33, 8'h44, 8'h11, 8'h22, 8'h66, 8'h55, 8'h88, 8'h77};
    fifo_read = 1'b1;
    repeat (1016) @(negedge clk);
    fifo_read = 1'b0;
    nvec++; if (fifo_count !== 11'd8) begin nerr++; $display("FAIL wrap_count: got %0d want 8", fifo_count); end
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (fifo_rddata !== exp[i]) begin nerr++; $display("FAIL wrap_byte%0d: got %02h want %02h", i, fifo_rddata, exp[i]); end
      pop1;
    end
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    flush;
    nvec++; if (overrun !== 1'b0 || fifo_count !== 11'd0) begin
      nerr++; $display("FAIL flush_state: overrun=%b count=%0d want 0/0", overrun, fifo_count); end
    $display("wrap past 1023 drained, flush cleared overrun");
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [5] = '{8'h03, 8'h06, 8'h05, 8'h08, 8'h07};
    logic [15:0] r = 16'h0708;
    int waited = 0;
    flush;
    mode_stereo = 1'b1;
    send_frame(24'h0102, 24'h0304, 16, 8, 1'b1);
    send_half(1'b0, 24'h0506, 16, 8);
    send_half(1'b1, {9'd0, r[15:1]}, 15, 8);
    i2s_bck = 1'b0; i2s_lrck = 1'b1; i2s_data = r[0];
    idle(8);
    i2s_bck = 1'b1;
    while (fifo_count !== 11'd5 && waited < 30) begin @(negedge clk); waited++; end
    nvec++; if (fifo_count !== 11'd5) begin nerr++; $display("FAIL b2b_first_push: count=%0d want 5", fifo_count); end
    fifo_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++; if (fifo_count !== 11'd5) begin nerr++; $display("FAIL b2b_count%0d: got %0d want 5", i, fifo_count); end
    end
    fifo_read = 1'b0;
    idle(8);
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (fifo_rddata !== exp[i]) begin nerr++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, fifo_rddata, exp[i]); end
      pop1;
    end
    $display("push+pop same cycle held count at 5");
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [4] = '{8'hFE, 8'hCA, 8'hEF, 8'hBE};
    flush;
    send_half(1'b0, 24'h1111, 16, 8);
    send_half(1'b1, 24'h22, 8, 8);
    fifo_reset = 1'b1; @(negedge clk); fifo_reset = 1'b0;
    for (int i = 0; i < 8; i++) bck_bit(1'b1, 1'b1, 8);
    idle(8);
    nvec++; if (fifo_count !== 11'd0) begin nerr++; $display("FAIL midflush_count: got %0d want 0", fifo_count); end
    send_frame(24'hCAFE, 24'hBEEF, 16, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd4) begin nerr++; $display("FAIL midflush_next_count: got %0d want 4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (fifo_rddata !== exp[i]) begin nerr++; $display("FAIL midflush_byte%0d: got %02h want %02h", i, fifo_rddata, exp[i]); end
      pop1;
    end
  endtask

  task automatic test_slots;
    flush;
    mode_stereo = 1'b0;
    send_frame(24'h123456, 24'h654321, 24, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd2) begin nerr++; $display("FAIL slot24_count: got %0d want 2", fifo_count); end
    nvec++; if (fifo_rddata !== 8'h34) begin nerr++; $display("FAIL slot24_byte0: got %02h want 34", fifo_rddata); end
    pop1;
    nvec++; if (fifo_rddata !== 8'h12) begin nerr++; $display("FAIL slot24_byte1: got %02h want 12", fifo_rddata); end
    pop1;
    mode_stereo = 1'b1;
    send_half(1'b0, 24'hABC, 12, 8);
    send_half(1'b1, 24'h1111, 16, 8);
    idle(8);
    nvec++; if (fifo_count !== 11'd0) begin nerr++; $display("FAIL short_half_count: got %0d want 0", fifo_count); end
    $display("24-bit slot truncated, 12-bit half-frame discarded");
  endtask

  task automatic test_disable;
    logic [7:0] exp [4] = '{8'h57, 8'h13, 8'h68, 8'h24};
    capture_enable = 1'b0;
    send_frame(24'h1357, 24'h2468, 16, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd0) begin nerr++; $display("FAIL disabled_count: got %0d want 0", fifo_count); end
    capture_enable = 1'b1;
    send_frame(24'h1357, 24'h2468, 16, 8, 1'b1);
    nvec++; if (fifo_count !== 11'd4) begin nerr++; $display("FAIL reenable_count: got %0d want 4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (fifo_rddata !== exp[i]) begin nerr++; $display("FAIL reenable_byte%0d: got %02h want %02h", i, fifo_rddata, exp[i]); end
      pop1;
    end
  endtask

  initial begin
    test_reset;
    test_stereo;
    test_mono;
    test_overrun;
    test_wrap_flush;
    test_back_to_back;
    test_reset_mid;
    test_slots;
    test_disable;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
